// File: rtl/priority_scan_encoder_if.sv
// Handshake bundle for priority_scan_encoder.
//   iLoad / iData : request source ORs a vector into the pending set
//   iAck          : consumer takes the index currently on oData
//   oValid/oData  : a pending index is offered (oData = 0 when idle)
//   oCount        : popcount of the pending set
//   oLast         : the offered index is the only one pending
//   oDbgState     : encoder state (0 = IDLE, 1 = EMIT) for checkers
//
// Handshake: oData is transferred on every rising edge where
// oValid && iAck. iAck while oValid is low is ignored. oValid never
// depends combinationally on iAck or iLoad.
interface priority_scan_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         iLoad;
  logic [N-1:0] iData;
  logic         iAck;
  logic         oValid;
  logic [W-1:0] oData;
  logic [W:0]   oCount;
  logic         oLast;
  logic         oDbgState;

  modport master (
    output iLoad, iData, iAck,
    input  oValid, oData, oCount, oLast, oDbgState
  );

  modport slave (
    input  iLoad, iData, iAck,
    output oValid, oData, oCount, oLast, oDbgState
  );
endinterface

// File: rtl/priority_scan_encoder.sv
// Registered priority scan encoder. Request vectors are ORed into a
// pending register; one set index is offered per handshake until the
// register drains.
//   MODE 0 : highest pending index first.
//   MODE 1 : round-robin, descending scan from ptr with wrap; after a
//            grant of k the scan restarts just below k.
// Ports:
//   iClk  : clock, rising edge
//   iRst  : asynchronous active-high reset
//   bus   : slave side of priority_scan_encoder_if
// All outputs are functions of registered state only.
module priority_scan_encoder #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input logic                     iClk,
  input logic                     iRst,
  priority_scan_encoder_if.slave  bus
);
  localparam int W = $clog2(N);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e       state_q;
  state_e       state_d;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  logic [W-1:0] sel_idx;
  logic         sel_found;
  logic         grant;
  logic [N-1:0] grant_mask;
  logic [W:0]   count;

  // Scan start: fixed priority is simply a scan that always starts at N-1.
  always_comb begin
    int start;
    int idx;
    sel_idx   = '0;
    sel_found = 1'b0;
    start     = (MODE == 0) ? (N - 1) : int'(ptr_q);
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = start - off;
      if (idx < 0) idx = idx + N;
      if (!sel_found && pending_q[idx[W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx[W-1:0];
      end
    end
  end

  assign count      = (W+1)'($countones(pending_q));
  assign grant      = (state_q == EMIT) && bus.iAck;
  assign grant_mask = grant ? ({{(N-1){1'b0}}, 1'b1} << sel_idx) : '0;

  // A bit acked and reloaded in the same cycle survives as a new request.
  assign pending_d = (pending_q & ~grant_mask) | (bus.iLoad ? bus.iData : '0);
  assign state_d   = (pending_d != '0) ? EMIT : IDLE;

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == 1 && grant) begin
      ptr_d = (sel_idx == '0) ? W'(N - 1) : sel_idx - 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= W'(N - 1);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.oValid    = (state_q == EMIT);
  assign bus.oData     = sel_found ? sel_idx : '0;
  assign bus.oCount    = count;
  assign bus.oLast     = (state_q == EMIT) && (count == (W+1)'(1));
  assign bus.oDbgState = state_q;
endmodule

// File: tb/tb_priority_scan_encoder.sv
module tb_priority_scan_encoder;
  localparam int N = 8;
  localparam int W = 3;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  priority_scan_encoder_if #(.N(N)) b0 ();
  priority_scan_encoder_if #(.N(N)) b1 ();

  priority_scan_encoder #(.N(N), .MODE(0)) u_fixed (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (b0)
  );

  priority_scan_encoder #(.N(N), .MODE(1)) u_rr (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (b1)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // A set of pending request numbers plus, for round-robin, the request
  // number the next search begins at.
  logic [N-1:0] m_pend  [2];
  int           m_start [2];

  function automatic int pick(input logic [N-1:0] p, input int mode, input int start);
    if (p == '0) return -1;
    if (mode == 0) begin
      for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
    end else begin
      for (int off = 0; off < N; off++) begin
        int j;
        j = (start - off + N) % N;
        if (p[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m]  = '0;
      m_start[m] = N - 1;
    end
  endtask

  task automatic model_update(input logic ld, input logic [N-1:0] dt, input logic ak);
    for (int m = 0; m < 2; m++) begin
      int k;
      k = pick(m_pend[m], m, m_start[m]);
      if (ak && k >= 0) begin
        m_pend[m][k] = 1'b0;
        if (m == 1) m_start[m] = (k + N - 1) % N;
      end
      if (ld) m_pend[m] = m_pend[m] | dt;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int m, input logic v, input logic [W-1:0] d,
                           input logic [W:0] c, input logic l, input logic st);
    int k;
    int cnt;
    k   = pick(m_pend[m], m, m_start[m]);
    cnt = $countones(m_pend[m]);
    chk($sformatf("m%0d_valid", m), 32'(v), 32'(k >= 0));
    chk($sformatf("m%0d_data", m), 32'(d), (k >= 0) ? 32'(k) : 32'd0);
    chk($sformatf("m%0d_count", m), 32'(c), 32'(cnt));
    chk($sformatf("m%0d_last", m), 32'(l), 32'(cnt == 1));
    chk($sformatf("m%0d_state", m), 32'(st), 32'(m_pend[m] != '0));
  endtask

  task automatic check_all();
    check_dut(0, b0.oValid, b0.oData, b0.oCount, b0.oLast, b0.oDbgState);
    check_dut(1, b1.oValid, b1.oData, b1.oCount, b1.oLast, b1.oDbgState);
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge: drive, take one rising edge, then check.
  task automatic step(input logic ld, input logic [N-1:0] dt, input logic ak);
    b0.iLoad = ld; b0.iData = dt; b0.iAck = ak;
    b1.iLoad = ld; b1.iData = dt; b1.iAck = ak;
    @(posedge iClk);
    model_update(ld, dt, ak);
    @(negedge iClk);
    check_all();
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_rr[9];
    int exp_fx[4];
    exp_rr = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    exp_fx = '{7, 5, 2, 1};

    iRst = 1'b1;
    b0.iLoad = 1'b0; b0.iData = '0; b0.iAck = 1'b0;
    b1.iLoad = 1'b0; b1.iData = '0; b1.iAck = 1'b0;
    model_reset();
    @(negedge iClk);
    @(negedge iClk);
    check_all();
    chk("rst_valid", 32'(b0.oValid), 0);
    chk("rst_count", 32'(b1.oCount), 0);
    iRst = 1'b0;

    // Fixed-order drain of 1010_0110.
    step(1'b1, 8'hA6, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(b0.oData), 32'(exp_fx[i]));
      chk("drain_count", 32'(b0.oCount), 32'(4 - i));
      chk("drain_last", 32'(b0.oLast), 32'(i == 3));
      step(1'b0, '0, 1'b1);
    end
    chk("drain_empty", 32'(b0.oValid), 0);

    // Backpressure holds the offered index.
    do_reset();
    step(1'b1, 8'h90, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", 32'(b0.oData), 7);
      chk("bp_count", 32'(b0.oCount), 2);
      step(1'b0, '0, 1'b0);
    end
    step(1'b0, '0, 1'b1);
    chk("bp_next", 32'(b0.oData), 4);
    step(1'b0, '0, 1'b1);
    chk("bp_empty", 32'(b0.oValid), 0);

    // Ack and reload of the same bit.
    do_reset();
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h81, 1'b1);
    chk("reload_data", 32'(b0.oData), 7);
    chk("reload_count", 32'(b0.oCount), 2);

    // Round-robin fairness with all lines requesting every cycle.
    do_reset();
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("rr_data", 32'(b1.oData), 32'(exp_rr[i]));
      chk("rr_valid", 32'(b1.oValid), 1);
      step(1'b1, 8'hFF, 1'b1);
    end

    // Round-robin wrap after granting index 0.
    do_reset();
    step(1'b1, 8'h01, 1'b0);
    chk("wrap_first", 32'(b1.oData), 0);
    step(1'b0, '0, 1'b1);
    step(1'b1, 8'h09, 1'b0);
    chk("wrap_three", 32'(b1.oData), 3);
    step(1'b0, '0, 1'b1);
    chk("wrap_zero", 32'(b1.oData), 0);

    // Asynchronous reset mid-drain.
    do_reset();
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    iRst = 1'b1;
    #1;
    chk("arst_valid", 32'(b0.oValid | b1.oValid), 0);
    chk("arst_data", 32'(b0.oData | b1.oData), 0);
    chk("arst_count", 32'(b0.oCount | b1.oCount), 0);
    chk("arst_last", 32'(b0.oLast | b1.oLast), 0);
    model_reset();
    @(negedge iClk);
    iRst = 1'b0;
    step(1'b1, '0, 1'b0);
    chk("zero_load", 32'(b0.oValid | b1.oValid), 0);
    step(1'b0, '0, 1'b1);
    chk("idle_ack", 32'(b1.oCount), 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic         ld;
      logic [N-1:0] dt;
      logic         ak;
      ld = ($urandom_range(0, 3) == 0);
      dt = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(0, 255));
      ak = ($urandom_range(0, 2) != 0);
      step(ld, dt, ak);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/priority_scan_encoder.md
# priority_scan_encoder

Parametrised, registered successor to the combinational 8-to-3 encoder. Latches a vector of N request lines into a pending register and emits the binary index of one set bit per handshake until the register drains. Supports fixed highest-first priority or round-robin order. New requests may merge at any cycle. Sits between request sources (switches, interrupt lines) and a consumer that takes one index at a time, such as a display or a dispatch unit.

## Interface
- N, default 8: number of request lines; N >= 2.
- MODE, default 0: 0 = fixed priority, highest index first; 1 = round-robin, descending with wrap.
- W (localparam) = $clog2(N): index width; 3 for N = 8.
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  reset; asynchronous, active-high.
- iLoad  input  1  when high, OR iData into the pending register this cycle.
- iData  input  N  request vector, sampled only when iLoad = 1.
- iAck  input  1  consumer accepts the current oData; only meaningful while oValid = 1.
- oValid  output  1  at least one request is pending.
- oData  output  W  index of the selected pending bit; 0 when oValid = 0.
- oCount  output  W+1  number of set bits in the pending register (popcount).
- oLast  output  1  oValid && oCount == 1.

## Operation
- State:
  - pending[N-1:0]
  - ptr[W-1:0], the round-robin search start; unused in MODE 0.
- Selection, combinational from registered state only:
  - MODE 0: the highest set index of pending.
  - MODE 1: the first set index found scanning ptr, ptr-1, …, 0, N-1, …, ptr+1.
- All outputs derive from pending and ptr only, so they are registered-equivalent: there is no input-to-output combinational path.
- Two-state view:
  - IDLE (pending == 0): oValid = 0.
  - EMIT (pending != 0): oValid = 1.
  - IDLE → EMIT on iLoad with iData != 0.
  - EMIT → IDLE when the last bit is acked and no new bit is loaded in the same cycle.
- Accept: a grant occurs when oValid && iAck.
- Next-state rule: pending_next = (pending & ~grant_mask) | (iLoad ? iData : 0).
  - grant_mask is the one-hot of oData on a grant, else 0.
  - If a bit is acked and reloaded in the same cycle, it stays set and is treated as a new request.
- ptr update, MODE 1 only: on a grant of index k, ptr ← (k == 0) ? N-1 : k-1. Otherwise ptr holds.
- iAck while oValid = 0 is ignored: no state change and no error.
- iLoad with iData = 0 is a no-op.
- oCount is a full popcount of pending. With N = 8 it ranges 0..8 in 4 bits.
- Reset (asynchronous, effective immediately, including mid-drain):
  - pending = 0, ptr = N-1.
  - oValid = 0, oData = 0, oCount = 0, oLast = 0.
  - Pending requests are discarded.

## Timing
- Load latency: iLoad at edge t sets pending at t. oValid, oData and oCount reflect the load in the cycle after edge t, i.e. one cycle of latency.
- Throughput: one grant per cycle with iAck held high. A vector with k bits set drains in k cycles.
- Backpressure: while oValid = 1 and iAck = 0, oData, oCount and ptr stay stable, except that oCount and oData may change if iLoad adds bits. In MODE 0 a newly loaded higher bit pre-empts the displayed index; this is permitted.
- Deassertion of iRst is synchronous to the system; the first edge after release may accept iLoad.

## Test plan
- Fixed order drain: MODE 0, N = 8, load 8'b1010_0110, iAck = 1.
  - oData sequence is 7, 5, 2, 1 on four consecutive cycles.
  - oCount is 4, 3, 2, 1; oLast is high on the 1.
  - oValid drops on the fifth cycle.
- Backpressure: MODE 0, load 8'h90, iAck = 0 for 5 cycles.
  - oData holds 7 and oCount holds 2.
  - Then iAck = 1 yields 4, followed by oValid = 0.
- Same-cycle ack and reload: MODE 0, pending 8'h80; iAck = 1 together with iLoad, iData = 8'h81.
  - Next cycle pending = 8'h81, oData = 7, oCount = 2.
- Round-robin fairness: MODE 1, iLoad = 1, iData = 8'hFF every cycle, iAck = 1.
  - Grant sequence is 7, 6, 5, 4, 3, 2, 1, 0, 7.
  - oValid never drops.
- Round-robin wrap: MODE 1, grant index 0 first (load 8'h01, ack).
  - Then load 8'h09: next grant is 3 (the scan starts at 7).
  - ptr then becomes 2, and the following grant is 0.
- Reset and degenerate inputs:
  - iRst asserted mid-drain of 8'hFF: all outputs are 0 immediately, without waiting for a clock edge.
  - After release, iLoad with iData = 0: oValid stays 0.
  - iAck while idle: no change.
